// File: rtl/fp32_maxmin_reduce.sv
// ---------------------------------------------------------------------------
// fp32_maxmin_reduce
//
// Streaming max/min reduction controller. It accepts a packet of FP32
// elements on a valid/ready stream. For every element after the first, it
// issues one compare (running accumulator vs. new element) to an external
// registered FP32 max/min comparator and waits for the result. When the
// packet ends, it presents the reduced value and the element count on a
// valid/ready output.
//
// Optional feature macro: FP32_REDUCE_NAN_STICKY_EN
//   When defined, the block tracks a sticky NaN flag. The flag is set by a
//   NaN first element or by a NaN comparator result. While the flag is set,
//   elements are only counted and are not compared, and m_data reads as
//   0xFFFFFFFF.
//
// Parameters:
//   CNT_W        width of the element counter and m_count (saturating)
//   CMP_TIMEOUT  cycles spent in WAIT without a result before the packet is
//                aborted with m_err (must be >= 1)
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_is_max            1 = max, 0 = min; latched with the first element
//   s_valid/s_ready     input element handshake
//   s_data, s_last      FP32 element, last-of-packet marker
//   cmp_valid           one-cycle compare request to the comparator
//   cmp_is_max          compare mode
//   cmp_a, cmp_b        accumulator operand, new-element operand
//   cmp_result_valid    comparator result strobe (one cycle after cmp_valid)
//   cmp_result          comparator result
//   m_valid/m_ready     result handshake
//   m_data, m_count     reduced value, element count
//   m_err               packet was aborted on comparator timeout
// ---------------------------------------------------------------------------
module fp32_maxmin_reduce #(
   parameter int CNT_W       = 16,
   parameter int CMP_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_is_max,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic             cmp_valid,
   output logic             cmp_is_max,
   output logic [31:0]      cmp_a,
   output logic [31:0]      cmp_b,
   input  logic             cmp_result_valid,
   input  logic [31:0]      cmp_result,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [CNT_W-1:0] m_count,
   output logic             m_err
);

   // The timer counts 0 .. CMP_TIMEOUT-1 while in WAIT, so WAIT lasts
   // exactly CMP_TIMEOUT cycles when no result arrives.
   localparam int TMR_W = (CMP_TIMEOUT < 2) ? 1 : $clog2(CMP_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CMP_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       acc_q;
   logic [CNT_W-1:0]  count_q;
   logic              mode_q;
   logic              last_pend_q;
   logic [TMR_W-1:0]  timer_q;
   logic              err_q;
   logic              xfer;
   logic              timer_hit;
   logic [CNT_W-1:0]  count_inc;

`ifdef FP32_REDUCE_NAN_STICKY_EN
   logic              nan_q;

   function automatic logic is_nan(input logic [31:0] d);
      return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
   endfunction
`endif

   assign xfer      = s_valid & s_ready;
   assign timer_hit = (timer_q == TMR_MAX);
   // The count saturates at all-ones instead of wrapping.
   assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so that every flop
   // samples the pre-edge values; blocking assignments here would create
   // order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // Next state and handshake outputs
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default value first. A path that
   // left a signal unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      m_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            s_ready = 1'b1;
            if (xfer) state_d = s_last ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            s_ready = 1'b1;
            if (xfer) begin
`ifdef FP32_REDUCE_NAN_STICKY_EN
               // With a NaN already seen, elements are only counted here.
               if (nan_q) state_d = s_last ? S_DONE : S_ACCUM;
               else       state_d = S_WAIT;
`else
               state_d = S_WAIT;
`endif
            end
         end
         S_WAIT: begin
            // A result in the final timer cycle still wins over the abort.
            if (cmp_result_valid) state_d = last_pend_q ? S_DONE : S_ACCUM;
            else if (timer_hit)   state_d = S_DONE;
         end
         S_DONE: begin
            m_valid = 1'b1;
            if (m_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath, compare request and status registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         count_q     <= '0;
         mode_q      <= 1'b0;
         last_pend_q <= 1'b0;
         timer_q     <= '0;
         err_q       <= 1'b0;
         cmp_valid   <= 1'b0;
         cmp_is_max  <= 1'b0;
         cmp_a       <= '0;
         cmp_b       <= '0;
`ifdef FP32_REDUCE_NAN_STICKY_EN
         nan_q       <= 1'b0;
`endif
      end else begin
         // The compare request is a single-cycle pulse.
         cmp_valid <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  acc_q   <= s_data;
                  mode_q  <= i_is_max;
                  count_q <= CNT_W'(1);
`ifdef FP32_REDUCE_NAN_STICKY_EN
                  nan_q   <= is_nan(s_data);
`endif
               end
            end
            S_ACCUM: begin
               if (xfer) begin
`ifdef FP32_REDUCE_NAN_STICKY_EN
                  if (nan_q) begin
                     count_q <= count_inc;
                  end else begin
                     cmp_a       <= acc_q;
                     cmp_b       <= s_data;
                     cmp_is_max  <= mode_q;
                     cmp_valid   <= 1'b1;
                     last_pend_q <= s_last;
                     timer_q     <= '0;
                  end
`else
                  cmp_a       <= acc_q;
                  cmp_b       <= s_data;
                  cmp_is_max  <= mode_q;
                  cmp_valid   <= 1'b1;
                  last_pend_q <= s_last;
                  timer_q     <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (!timer_hit) timer_q <= timer_q + TMR_W'(1);
               if (cmp_result_valid) begin
                  acc_q   <= cmp_result;
                  count_q <= count_inc;
`ifdef FP32_REDUCE_NAN_STICKY_EN
                  if (is_nan(cmp_result)) nan_q <= 1'b1;
`endif
               end else if (timer_hit) begin
                  err_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (m_ready) begin
                  err_q <= 1'b0;
`ifdef FP32_REDUCE_NAN_STICKY_EN
                  nan_q <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Result outputs (held stable while waiting in DONE)
   // -------------------------------------------------------------------------
`ifdef FP32_REDUCE_NAN_STICKY_EN
   assign m_data  = nan_q ? 32'hFFFF_FFFF : acc_q;
`else
   assign m_data  = acc_q;
`endif
   assign m_count = count_q;
   assign m_err   = err_q;

endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// ---------------------------------------------------------------------------
// tb_fp32_maxmin_reduce
//
// Directed bench for fp32_maxmin_reduce. A small comparator responder
// answers each cmp_valid one cycle later. All expected values are
// hand-computed constants. Build with +define+FP32_REDUCE_NAN_STICKY_EN to
// exercise the sticky-NaN variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp32_maxmin_reduce;

   localparam int CNT_W       = 16;
   localparam int CMP_TIMEOUT = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_is_max;
   logic             s_valid;
   logic             s_ready;
   logic [31:0]      s_data;
   logic             s_last;
   logic             cmp_valid;
   logic             cmp_is_max;
   logic [31:0]      cmp_a;
   logic [31:0]      cmp_b;
   logic             cmp_result_valid;
   logic [31:0]      cmp_result;
   logic             m_valid;
   logic             m_ready;
   logic [31:0]      m_data;
   logic [CNT_W-1:0] m_count;
   logic             m_err;

   fp32_maxmin_reduce #(.CNT_W(CNT_W), .CMP_TIMEOUT(CMP_TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_is_max         (i_is_max),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .s_last           (s_last),
      .cmp_valid        (cmp_valid),
      .cmp_is_max       (cmp_is_max),
      .cmp_a            (cmp_a),
      .cmp_b            (cmp_b),
      .cmp_result_valid (cmp_result_valid),
      .cmp_result       (cmp_result),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_data           (m_data),
      .m_count          (m_count),
      .m_err            (m_err)
   );

   always #5 clk = ~clk;

   // ---------------- comparator responder ----------------
   logic        cmp_en;      // 0 = comparator never answers
   logic        inj_rv;      // manually injected (late) result strobe
   logic [31:0] inj_res;
   logic        mdl_rv;
   logic [31:0] mdl_res;

   function automatic logic [31:0] fsel(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_max);
      logic a_gt_b;
      if (a[31] != b[31]) a_gt_b = b[31];
      else if (!a[31])    a_gt_b = (a[30:0] > b[30:0]);
      else                a_gt_b = (a[30:0] < b[30:0]);
      return (is_max == a_gt_b) ? a : b;
   endfunction

   always @(posedge clk) begin
      mdl_rv  <= cmp_en & cmp_valid;
      mdl_res <= fsel(cmp_a, cmp_b, cmp_is_max);
   end

   assign cmp_result_valid = mdl_rv | inj_rv;
   assign cmp_result       = inj_rv ? inj_res : mdl_res;

   // ---------------- cmp_valid pulse monitor ----------------
   int  cmp_pulses = 0;
   int  cmp_wide   = 0;   // cycles where cmp_valid stayed high two in a row
   logic cmp_prev  = 1'b0;

   always @(negedge clk) begin
      if (cmp_valid) cmp_pulses++;
      if (cmp_valid && cmp_prev) cmp_wide++;
      cmp_prev <= cmp_valid;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_elem(input logic [31:0] d, input logic last, input logic mode);
      logic got;
      got = 1'b0;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      i_is_max = mode;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("s_ready_wait", {31'd0, got}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_mvalid(output int cycles);
      logic got;
      got    = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (m_valid) begin
            got    = 1'b1;
            cycles = i;
            break;
         end
      end
      check("m_valid_wait", {31'd0, got}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"},    {31'd0, s_ready},    32'd1);
      check({tag, "_m_valid"},    {31'd0, m_valid},    32'd0);
      check({tag, "_cmp_valid"},  {31'd0, cmp_valid},  32'd0);
      check({tag, "_cmp_is_max"}, {31'd0, cmp_is_max}, 32'd0);
      check({tag, "_cmp_a"},      cmp_a,               32'd0);
      check({tag, "_cmp_b"},      cmp_b,               32'd0);
      check({tag, "_m_data"},     m_data,              32'd0);
      check({tag, "_m_count"},    {16'd0, m_count},    32'd0);
      check({tag, "_m_err"},      {31'd0, m_err},      32'd0);
   endtask

   initial begin
      int p0, w0, cyc;

      rst = 1'b1; i_is_max = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      m_ready = 1'b1; cmp_en = 1'b1; inj_rv = 1'b0; inj_res = '0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst");

      // ---- max of {1.0, -2.0, 3.5} ----
      @(posedge clk); #1;
      p0 = cmp_pulses; w0 = cmp_wide;
      send_elem(32'h3F80_0000, 1'b0, 1'b1);
      send_elem(32'hC000_0000, 1'b0, 1'b1);
      @(negedge clk);   // cycle after accept: the registered request is up
      check("max_cmp_valid",  {31'd0, cmp_valid},  32'd1);
      check("max_cmp_a",      cmp_a,               32'h3F80_0000);
      check("max_cmp_b",      cmp_b,               32'hC000_0000);
      check("max_cmp_is_max", {31'd0, cmp_is_max}, 32'd1);
      check("max_s_ready_wait_state", {31'd0, s_ready}, 32'd0);
      send_elem(32'h4060_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      check("max_m_data",  m_data,            32'h4060_0000);
      check("max_m_count", {16'd0, m_count},  32'd3);
      check("max_m_err",   {31'd0, m_err},    32'd0);
      check("max_pulses",  cmp_pulses - p0,   32'd2);
      check("max_pulse_w", cmp_wide - w0,     32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("max_m_valid_drop", {31'd0, m_valid}, 32'd0);

      // ---- min of the same packet; i_is_max toggles mid-packet ----
      @(posedge clk); #1;
      send_elem(32'h3F80_0000, 1'b0, 1'b0);
      send_elem(32'hC000_0000, 1'b0, 1'b1);
      send_elem(32'h4060_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      check("min_m_data",  m_data,           32'hC000_0000);
      check("min_m_count", {16'd0, m_count}, 32'd3);
      @(posedge clk); #1;

      // ---- single element ----
      p0 = cmp_pulses;
      send_elem(32'h4120_0000, 1'b1, 1'b1);
      @(negedge clk);   // first cycle after the accepting edge
      check("single_m_valid", {31'd0, m_valid},  32'd1);
      check("single_m_data",  m_data,            32'h4120_0000);
      check("single_m_count", {16'd0, m_count},  32'd1);
      check("single_pulses",  cmp_pulses - p0,   32'd0);
      @(posedge clk); #1;

      // ---- backpressure in DONE: max of {2.0, 1.0} ----
      m_ready = 1'b0;
      send_elem(32'h4000_0000, 1'b0, 1'b1);
      send_elem(32'h3F80_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 32'h4120_0000; s_last = 1'b1; i_is_max = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_m_valid", {31'd0, m_valid}, 32'd1);
         check("bp_m_data",  m_data,           32'h4000_0000);
         check("bp_m_count", {16'd0, m_count}, 32'd2);
         check("bp_s_ready", {31'd0, s_ready}, 32'd0);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;   // handshake edge: back to IDLE
      check("bp_idle_s_ready", {31'd0, s_ready}, 32'd1);
      check("bp_idle_m_valid", {31'd0, m_valid}, 32'd0);
      @(posedge clk); #1;   // held element accepted here
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      check("bp_next_m_valid", {31'd0, m_valid}, 32'd1);
      check("bp_next_m_data",  m_data,           32'h4120_0000);
      check("bp_next_m_count", {16'd0, m_count}, 32'd1);
      @(posedge clk); #1;

      // ---- comparator timeout ----
      cmp_en = 1'b0;
      send_elem(32'h3F80_0000, 1'b0, 1'b1);
      send_elem(32'h4000_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      // WAIT begins the cycle after accept and lasts about CMP_TIMEOUT cycles.
      check("to_latency_ok",
            {31'd0, (cyc >= CMP_TIMEOUT + 1) && (cyc <= CMP_TIMEOUT + 2)}, 32'd1);
      check("to_m_err",   {31'd0, m_err},    32'd1);
      check("to_m_data",  m_data,            32'h3F80_0000);
      check("to_m_count", {16'd0, m_count},  32'd1);
      @(posedge clk); #1;
      cmp_en = 1'b1;
      send_elem(32'hC000_0000, 1'b0, 1'b1);
      send_elem(32'hBF80_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      check("to_next_m_err",   {31'd0, m_err},   32'd0);
      check("to_next_m_data",  m_data,           32'hBF80_0000);
      check("to_next_m_count", {16'd0, m_count}, 32'd2);
      @(posedge clk); #1;

      // ---- reset while in WAIT, then a late result ----
      cmp_en = 1'b0;
      send_elem(32'h3F80_0000, 1'b0, 1'b1);
      send_elem(32'h4000_0000, 1'b1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      inj_rv = 1'b1; inj_res = 32'h1234_5678;
      @(negedge clk);
      check_reset_outputs("wrst");
      @(posedge clk); #1;
      inj_rv = 1'b0;
      @(negedge clk);
      check_reset_outputs("late");
      cmp_en = 1'b1;
      @(posedge clk); #1;
      send_elem(32'h4040_0000, 1'b0, 1'b0);
      send_elem(32'h4000_0000, 1'b1, 1'b0);
      wait_mvalid(cyc);
      check("post_rst_m_data",  m_data,           32'h4000_0000);
      check("post_rst_m_count", {16'd0, m_count}, 32'd2);
      @(posedge clk); #1;

      // ---- NaN first element ----
      p0 = cmp_pulses;
      send_elem(32'h7FC0_0000, 1'b0, 1'b1);
      send_elem(32'h3F80_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      check("nan_m_count", {16'd0, m_count}, 32'd2);
`ifdef FP32_REDUCE_NAN_STICKY_EN
      check("nan_m_data",  m_data,          32'hFFFF_FFFF);
      check("nan_pulses",  cmp_pulses - p0, 32'd0);
`else
      // Without NaN tracking the pair is compared normally; the responder
      // orders 0x7FC00000 above 1.0.
      check("nan_m_data",  m_data,          32'h7FC0_0000);
      check("nan_pulses",  cmp_pulses - p0, 32'd1);
`endif
      @(posedge clk); #1;
      send_elem(32'h3F80_0000, 1'b1, 1'b1);
      wait_mvalid(cyc);
      check("nan_clear_m_data", m_data, 32'h3F80_0000);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case a wait loop is somehow bypassed.
   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
